// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: shift operations and FSM states.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRsv = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/n_bit_shift_left.sv
// Logical left shift by one bit position, zero fill.
module n_bit_shift_left #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data
);

  assign o_data = {i_data[N-2:0], 1'b0};

endmodule

// File: rtl/shift_sequencer_step.sv
// Combinational one-bit shift step selected by op; the reserved op passes data through.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_data,
  input  op_e          i_op,
  output logic [N-1:0] o_data
);

  logic [N-1:0] w_left;

  n_bit_shift_left #(
    .N(N)
  ) u_left (
    .i_data(i_data),
    .o_data(w_left)
  );

  always_comb begin
    o_data = i_data;
    unique case (i_op)
      OpSll:   o_data = w_left;
      OpSrl:   o_data = {1'b0, i_data[N-1:1]};
      OpSra:   o_data = {i_data[N-1], i_data[N-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: one bit per clock under a start/result valid-ready handshake,
// with synchronous kill and asynchronous reset.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [N-1:0]       operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               kill,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [N-1:0]       result,
  output logic               busy
);

  // Count must be able to hold N itself when an oversized shamt saturates.
  localparam int unsigned CntW  = $clog2(N + 1);
  localparam int unsigned WideW = (SHAMT_W > CntW) ? SHAMT_W : CntW;

  state_e            r_state, w_state_d;
  op_e               r_op, w_op_d, w_op_in;
  logic [N-1:0]      r_data, w_data_d, w_step;
  logic [CntW-1:0]   r_count, w_count_d, w_eff_amt;
  logic [WideW-1:0]  w_shamt_wide;

  assign w_op_in = op_e'(op);

  always_comb begin
    w_shamt_wide = WideW'(shamt);
    if (w_op_in == OpRsv) begin
      w_eff_amt = '0;
    end else if (w_shamt_wide >= WideW'(N)) begin
      w_eff_amt = CntW'(N);
    end else begin
      w_eff_amt = CntW'(w_shamt_wide);
    end
  end

  shift_step #(
    .N(N)
  ) u_step (
    .i_data(r_data),
    .i_op  (r_op),
    .o_data(w_step)
  );

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_data_d     = r_data;
    w_count_d    = r_count;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid && !kill) begin
          w_data_d  = operand;
          w_op_d    = w_op_in;
          w_count_d = w_eff_amt;
          w_state_d = (w_eff_amt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (kill) begin
          w_state_d = StIdle;
        end else begin
          w_data_d  = w_step;
          w_count_d = r_count - CntW'(1);
          if (r_count == CntW'(1)) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        result_valid = 1'b1;
        // kill wins over a simultaneous accept; the result is dropped either way.
        if (kill || result_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op    <= OpSll;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_data  <= w_data_d;
      r_count <= w_count_d;
    end
  end

  assign result = r_data;
  assign busy   = (r_state != StIdle);

endmodule
